// File: rtl/cv32e40p_ex_handshake_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_ex_handshake_ctrl
//
// EX-side responder of the ID/EX pipeline handshake. It looks at the EX-stage
// enables latched by ID/EX and at the ready signals of the functional units
// and decides when EX retires the current instruction (ex_valid_o) and when
// it can take the next one (ex_ready_o).
//
// Fault handling: when a fault is flagged on a completed result, ID/EX is
// held and the instruction is replayed through a one-cycle REPLAY state, up
// to MAX_RETRY times per instruction. One more fault after that, or a unit
// that stays not-ready for 2**TIMEOUT_W-1 consecutive cycles, drops the
// block into a sticky FATAL state that only rst_n clears.
//
// Handshake semantics: an instruction is present in EX while any enable is
// high. It retires in the cycle ex_valid_o is high; ex_ready_o high means ID
// may advance into EX at the next clock edge. With an instruction present,
// ex_valid_o and ex_ready_o are high together; with no instruction present
// in EXEC, ex_ready_o is high and ex_valid_o low.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   alu/mult/apu_en_ex_i,
//   data_req_ex_i             which units the EX instruction uses
//   alu/mult/apu_ready_i,
//   lsu_ready_ex_i            per-unit done
//   wb_ready_i                write-back can take the result
//   lsu_misaligned_i          LSU access needs a second transfer
//   ft_error_i                fault on the current EX result
//   ex_ready_o, ex_valid_o    handshake towards ID (combinational)
//   data_misaligned_o         registered; second misaligned access request
//   replay_o                  registered; one-cycle re-execute strobe
//   fault_uncorrectable_o     registered; sticky fatal flag
//   replay_count_o            saturating count of replays since reset
//   dbg_state, dbg_retry_cnt,
//   dbg_wd_cnt                internal state for observation
// -----------------------------------------------------------------------------
module cv32e40p_ex_handshake_ctrl #(
    parameter int MAX_RETRY = 2,
    parameter int TIMEOUT_W = 8,
    localparam int RW = $clog2(MAX_RETRY + 2)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_en_ex_i,
    input  logic                 mult_en_ex_i,
    input  logic                 apu_en_ex_i,
    input  logic                 data_req_ex_i,
    input  logic                 alu_ready_i,
    input  logic                 mult_ready_i,
    input  logic                 apu_ready_i,
    input  logic                 lsu_ready_ex_i,
    input  logic                 wb_ready_i,
    input  logic                 lsu_misaligned_i,
    input  logic                 ft_error_i,
    output logic                 ex_ready_o,
    output logic                 ex_valid_o,
    output logic                 data_misaligned_o,
    output logic                 replay_o,
    output logic                 fault_uncorrectable_o,
    output logic [15:0]          replay_count_o,
    output logic [1:0]           dbg_state,
    output logic [RW-1:0]        dbg_retry_cnt,
    output logic [TIMEOUT_W-1:0] dbg_wd_cnt
);

    localparam logic [1:0] EXEC   = 2'd0;
    localparam logic [1:0] MISAL  = 2'd1;
    localparam logic [1:0] REPLAY = 2'd2;
    localparam logic [1:0] FATAL  = 2'd3;

    localparam logic [RW-1:0]        RETRY_LIMIT = RW'(MAX_RETRY);
    // Value one below the trip point: the stall cycle that sees this count
    // pushes the counter to all-ones and moves to FATAL on the same edge.
    localparam logic [TIMEOUT_W-1:0] WD_LAST     = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    logic [1:0]           state, state_nxt;
    logic [RW-1:0]        retry_cnt, retry_nxt;
    logic [TIMEOUT_W-1:0] wd_cnt, wd_nxt;
    logic                 ret_misal, ret_misal_nxt;
    logic [15:0]          replay_cnt_nxt;

    logic inst, unit_rdy, done, stall, fault_chk, active;

    always_comb begin
        inst     = alu_en_ex_i | mult_en_ex_i | apu_en_ex_i | data_req_ex_i;
        unit_rdy = (!alu_en_ex_i   | alu_ready_i)  &
                   (!mult_en_ex_i  | mult_ready_i) &
                   (!apu_en_ex_i   | apu_ready_i)  &
                   (!data_req_ex_i | lsu_ready_ex_i);
        done     = inst & unit_rdy & wb_ready_i;
        // Only genuine unit stalls feed the watchdog; back-pressure from WB does not.
        stall    = inst & !unit_rdy;

        ex_ready_o     = 1'b0;
        ex_valid_o     = 1'b0;
        fault_chk      = 1'b0;
        active         = 1'b0;
        state_nxt      = state;
        retry_nxt      = retry_cnt;
        wd_nxt         = wd_cnt;
        ret_misal_nxt  = ret_misal;
        replay_cnt_nxt = replay_count_o;

        case (state)
            EXEC: begin
                active     = 1'b1;
                ex_ready_o = !inst | (done & !ft_error_i & !lsu_misaligned_i);
                ex_valid_o = inst & ex_ready_o;
                fault_chk  = done & ft_error_i;
                if (done && !ft_error_i && lsu_misaligned_i) begin
                    state_nxt = MISAL;
                end
            end
            MISAL: begin
                active     = 1'b1;
                ex_ready_o = lsu_ready_ex_i & wb_ready_i & !ft_error_i;
                ex_valid_o = ex_ready_o;
                fault_chk  = lsu_ready_ex_i & wb_ready_i & ft_error_i;
                if (ex_valid_o) begin
                    state_nxt = EXEC;
                end
            end
            REPLAY: begin
                state_nxt = ret_misal ? MISAL : EXEC;
            end
            default: begin
                state_nxt = FATAL;
            end
        endcase

        if (active) begin
            if (ex_valid_o) begin
                retry_nxt = '0;
            end
            wd_nxt = stall ? wd_cnt + TIMEOUT_W'(1) : '0;
            // Fault wins over the misaligned second access in the same cycle.
            if (fault_chk) begin
                if (retry_cnt < RETRY_LIMIT) begin
                    state_nxt     = REPLAY;
                    retry_nxt     = retry_cnt + RW'(1);
                    ret_misal_nxt = (state == MISAL);
                    if (replay_count_o != 16'hFFFF) begin
                        replay_cnt_nxt = replay_count_o + 16'd1;
                    end
                end else begin
                    state_nxt = FATAL;
                end
            end else if (stall && wd_cnt == WD_LAST) begin
                state_nxt = FATAL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= EXEC;
            retry_cnt             <= '0;
            wd_cnt                <= '0;
            ret_misal             <= 1'b0;
            replay_count_o        <= '0;
            data_misaligned_o     <= 1'b0;
            replay_o              <= 1'b0;
            fault_uncorrectable_o <= 1'b0;
        end else begin
            state                 <= state_nxt;
            retry_cnt             <= retry_nxt;
            wd_cnt                <= wd_nxt;
            ret_misal             <= ret_misal_nxt;
            replay_count_o        <= replay_cnt_nxt;
            // Registered outputs are decoded from the next state so they line up
            // with the state they describe.
            data_misaligned_o     <= (state_nxt == MISAL);
            replay_o              <= (state_nxt == REPLAY);
            fault_uncorrectable_o <= (state_nxt == FATAL);
        end
    end

    assign dbg_state     = state;
    assign dbg_retry_cnt = retry_cnt;
    assign dbg_wd_cnt    = wd_cnt;

endmodule

// File: tb/tb_cv32e40p_ex_handshake_ctrl.sv
module tb_cv32e40p_ex_handshake_ctrl;

    localparam logic [1:0] S_EXEC   = 2'd0;
    localparam logic [1:0] S_MISAL  = 2'd1;
    localparam logic [1:0] S_REPLAY = 2'd2;
    localparam logic [1:0] S_FATAL  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        alu_en, mult_en, apu_en, data_req;
    logic        alu_rdy, mult_rdy, apu_rdy, lsu_rdy;
    logic        wb_rdy, lsu_mis, ft_err;
    logic        ex_ready, ex_valid, data_mis, replay, fault_unc;
    logic [15:0] replay_cnt;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_retry;
    logic [7:0]  dbg_wd;

    int checks = 0;
    int errors = 0;

    cv32e40p_ex_handshake_ctrl #(.MAX_RETRY(2), .TIMEOUT_W(8)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .alu_en_ex_i           (alu_en),
        .mult_en_ex_i          (mult_en),
        .apu_en_ex_i           (apu_en),
        .data_req_ex_i         (data_req),
        .alu_ready_i           (alu_rdy),
        .mult_ready_i          (mult_rdy),
        .apu_ready_i           (apu_rdy),
        .lsu_ready_ex_i        (lsu_rdy),
        .wb_ready_i            (wb_rdy),
        .lsu_misaligned_i      (lsu_mis),
        .ft_error_i            (ft_err),
        .ex_ready_o            (ex_ready),
        .ex_valid_o            (ex_valid),
        .data_misaligned_o     (data_mis),
        .replay_o              (replay),
        .fault_uncorrectable_o (fault_unc),
        .replay_count_o        (replay_cnt),
        .dbg_state             (dbg_state),
        .dbg_retry_cnt         (dbg_retry),
        .dbg_wd_cnt            (dbg_wd)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vector record ----------------
    typedef struct {
        string       name;
        logic [3:0]  en;    // {alu, mult, apu, data_req}
        logic [3:0]  rdy;   // {alu, mult, apu, lsu}
        logic        wb;
        logic        mis;
        logic        ft;
        logic        er;    // ex_ready_o during the cycle
        logic        ev;    // ex_valid_o during the cycle
        logic [1:0]  st;    // state after the edge
        logic        dm;
        logic        rp;
        logic        fu;
        logic [15:0] rc;
        logic [1:0]  rt;
        logic [7:0]  wd;
    } vec_t;

    function automatic vec_t v(string name, logic [3:0] en, logic [3:0] rdy,
                               logic wb, logic mis, logic ft, logic er, logic ev,
                               logic [1:0] st, logic dm, logic rp, logic fu,
                               logic [15:0] rc, logic [1:0] rt, logic [7:0] wd);
        vec_t r;
        r.name = name; r.en = en; r.rdy = rdy; r.wb = wb; r.mis = mis; r.ft = ft;
        r.er = er; r.ev = ev; r.st = st; r.dm = dm; r.rp = rp; r.fu = fu;
        r.rc = rc; r.rt = rt; r.wd = wd;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [3:0] en, input logic [3:0] rdy,
                         input logic wb, input logic mis, input logic ft);
        {alu_en, mult_en, apu_en, data_req} = en;
        {alu_rdy, mult_rdy, apu_rdy, lsu_rdy} = rdy;
        wb_rdy  = wb;
        lsu_mis = mis;
        ft_err  = ft;
    endtask

    // Entered just after a rising edge: apply inputs, check the combinational
    // handshake mid-cycle, then check registered state after the next edge.
    task automatic run_vec(input vec_t t);
        drive(t.en, t.rdy, t.wb, t.mis, t.ft);
        @(negedge clk);
        chk({t.name, " ex_ready"}, 32'(ex_ready), 32'(t.er));
        chk({t.name, " ex_valid"}, 32'(ex_valid), 32'(t.ev));
        @(posedge clk);
        #1;
        chk({t.name, " state"},      32'(dbg_state),  32'(t.st));
        chk({t.name, " misaligned"}, 32'(data_mis),   32'(t.dm));
        chk({t.name, " replay"},     32'(replay),     32'(t.rp));
        chk({t.name, " fatal"},      32'(fault_unc),  32'(t.fu));
        chk({t.name, " replay_cnt"}, 32'(replay_cnt), 32'(t.rc));
        chk({t.name, " retry_cnt"},  32'(dbg_retry),  32'(t.rt));
        chk({t.name, " wd_cnt"},     32'(dbg_wd),     32'(t.wd));
    endtask

    // Asserts rst_n asynchronously mid-cycle, checks reset values before any
    // clock edge, releases on a falling edge and returns just after a rising edge.
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
        #1;
        chk({nm, " rst state"},      32'(dbg_state),  32'(S_EXEC));
        chk({nm, " rst misaligned"}, 32'(data_mis),   32'd0);
        chk({nm, " rst replay"},     32'(replay),     32'd0);
        chk({nm, " rst fatal"},      32'(fault_unc),  32'd0);
        chk({nm, " rst replay_cnt"}, 32'(replay_cnt), 32'd0);
        chk({nm, " rst retry_cnt"},  32'(dbg_retry),  32'd0);
        chk({nm, " rst wd_cnt"},     32'(dbg_wd),     32'd0);
        chk({nm, " rst ex_ready"},   32'(ex_ready),   32'd1);
        chk({nm, " rst ex_valid"},   32'(ex_valid),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);

        //           name          en       rdy      wb  mis ft   er  ev  st        dm  rp  fu  rc     rt    wd
        tbl.push_back(v("idle",     4'b0000, 4'b0000, 1, 0, 0,   1, 0, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("alu",      4'b1000, 4'b1000, 1, 0, 0,   1, 1, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("mul_w1",   4'b0100, 4'b0000, 1, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd1));
        tbl.push_back(v("mul_w2",   4'b0100, 4'b0000, 1, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd2));
        tbl.push_back(v("mul_w3",   4'b0100, 4'b0000, 1, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd3));
        tbl.push_back(v("mul_done", 4'b0100, 4'b0100, 1, 0, 0,   1, 1, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("wb_hold",  4'b1000, 4'b1000, 0, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("ld_mis1",  4'b0001, 4'b0001, 1, 1, 0,   0, 0, S_MISAL,  1, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("ld_wait",  4'b0001, 4'b0000, 1, 0, 0,   0, 0, S_MISAL,  1, 0, 0, 16'd0, 2'd0, 8'd1));
        tbl.push_back(v("ld_mis2",  4'b0001, 4'b0001, 1, 0, 0,   1, 1, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));
        tbl.push_back(v("ft_1",     4'b1000, 4'b1000, 1, 0, 1,   0, 0, S_REPLAY, 0, 1, 0, 16'd1, 2'd1, 8'd0));
        tbl.push_back(v("rp_1",     4'b1000, 4'b1000, 1, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd1, 2'd1, 8'd0));
        tbl.push_back(v("ft_2",     4'b1000, 4'b1000, 1, 0, 1,   0, 0, S_REPLAY, 0, 1, 0, 16'd2, 2'd2, 8'd0));
        tbl.push_back(v("rp_2",     4'b1000, 4'b1000, 1, 0, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd2, 2'd2, 8'd0));
        tbl.push_back(v("clean_3",  4'b1000, 4'b1000, 1, 0, 0,   1, 1, S_EXEC,   0, 0, 0, 16'd2, 2'd0, 8'd0));
        tbl.push_back(v("ft_mis",   4'b0001, 4'b0001, 1, 1, 1,   0, 0, S_REPLAY, 0, 1, 0, 16'd3, 2'd1, 8'd0));
        tbl.push_back(v("rp_ftmis", 4'b0001, 4'b0001, 1, 1, 0,   0, 0, S_EXEC,   0, 0, 0, 16'd3, 2'd1, 8'd0));
        tbl.push_back(v("ld_mis_b", 4'b0001, 4'b0001, 1, 1, 0,   0, 0, S_MISAL,  1, 0, 0, 16'd3, 2'd1, 8'd0));
        tbl.push_back(v("misal_ft", 4'b0001, 4'b0001, 1, 0, 1,   0, 0, S_REPLAY, 0, 1, 0, 16'd4, 2'd2, 8'd0));
        tbl.push_back(v("rp_ret",   4'b0001, 4'b0001, 1, 0, 0,   0, 0, S_MISAL,  1, 0, 0, 16'd4, 2'd2, 8'd0));
        tbl.push_back(v("misal_ok", 4'b0001, 4'b0001, 1, 0, 0,   1, 1, S_EXEC,   0, 0, 0, 16'd4, 2'd0, 8'd0));

        #2;
        do_reset("init");
        foreach (tbl[i]) run_vec(tbl[i]);

        // Retries exhausted: third consecutive faulty completion is fatal.
        do_reset("pre_fatal");
        run_vec(v("f5_ft1", 4'b1000, 4'b1000, 1, 0, 1, 0, 0, S_REPLAY, 0, 1, 0, 16'd1, 2'd1, 8'd0));
        run_vec(v("f5_rp1", 4'b1000, 4'b1000, 1, 0, 0, 0, 0, S_EXEC,   0, 0, 0, 16'd1, 2'd1, 8'd0));
        run_vec(v("f5_ft2", 4'b1000, 4'b1000, 1, 0, 1, 0, 0, S_REPLAY, 0, 1, 0, 16'd2, 2'd2, 8'd0));
        run_vec(v("f5_rp2", 4'b1000, 4'b1000, 1, 0, 0, 0, 0, S_EXEC,   0, 0, 0, 16'd2, 2'd2, 8'd0));
        run_vec(v("f5_ft3", 4'b1000, 4'b1000, 1, 0, 1, 0, 0, S_FATAL,  0, 0, 1, 16'd2, 2'd2, 8'd0));
        run_vec(v("f5_stk", 4'b1000, 4'b1000, 1, 0, 0, 0, 0, S_FATAL,  0, 0, 1, 16'd2, 2'd2, 8'd0));
        run_vec(v("f5_idl", 4'b0000, 4'b0000, 1, 0, 0, 0, 0, S_FATAL,  0, 0, 1, 16'd2, 2'd2, 8'd0));

        // Watchdog: APU never ready. One cycle short of the limit stays in EXEC.
        do_reset("pre_wd");
        drive(4'b0010, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (254) @(posedge clk);
        #1;
        chk("wd 254 state", 32'(dbg_state), 32'(S_EXEC));
        chk("wd 254 count", 32'(dbg_wd),    32'd254);
        chk("wd 254 fatal", 32'(fault_unc), 32'd0);
        @(posedge clk);
        #1;
        chk("wd 255 state",    32'(dbg_state), 32'(S_FATAL));
        chk("wd 255 fatal",    32'(fault_unc), 32'd1);
        chk("wd 255 ex_ready", 32'(ex_ready),  32'd0);
        run_vec(v("wd_stk", 4'b0000, 4'b0000, 1, 0, 0, 0, 0, S_FATAL, 0, 0, 1, 16'd0, 2'd0, 8'd255));

        // Reset in the middle of a replay and of a misaligned access.
        do_reset("post_wd");
        run_vec(v("r_ft",  4'b1000, 4'b1000, 1, 0, 1, 0, 0, S_REPLAY, 0, 1, 0, 16'd1, 2'd1, 8'd0));
        do_reset("mid_replay");
        run_vec(v("r_mis", 4'b0001, 4'b0001, 1, 1, 0, 0, 0, S_MISAL,  1, 0, 0, 16'd0, 2'd0, 8'd0));
        do_reset("mid_misal");
        run_vec(v("r_alu", 4'b1000, 4'b1000, 1, 0, 0, 1, 1, S_EXEC,   0, 0, 0, 16'd0, 2'd0, 8'd0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
